// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the adder4 round-robin sequencer.
package adder_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [3:0] ADDC_DEF = 4'b0011;

    // Next round-robin pointer after serving ptr, wrapping at nreq.
    function automatic int rr_next(input int ptr, input int nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/add3_sel_dp.sv
// Combinational add-constant / nibble-select datapath shared by all requesters.
module add3_sel_dp
    import adder_seq_pkg::*;
#(
    parameter logic [3:0] ADDC = ADDC_DEF
) (
    input  logic [2:0] a,
    input  logic       sel,
    output logic [1:0] out
);

    logic [3:0] tmp;

    // 3+7 still fits in 4 bits, so the adder carry-out is simply dropped.
    assign tmp = ADDC + {1'b0, a};
    assign out = sel ? tmp[1:0] : tmp[3:2];

endmodule

// File: rtl/adder4_rr_sequencer.sv
// Round-robin arbiter feeding one shared add3_sel_dp into a one-entry response register.
// Define ADDER_SEQ_STATS_EN to add the saturating stall_cnt output.
module adder4_rr_sequencer
    import adder_seq_pkg::*;
#(
    parameter int         NREQ = 4,
    parameter int         IDW  = 2,
    parameter logic [3:0] ADDC = ADDC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_a,
    input  logic [NREQ-1:0]   req_sel,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_out,
    output logic [IDW-1:0]    rsp_id
`ifdef ADDER_SEQ_STATS_EN
    ,
    output logic [7:0]        stall_cnt
`endif
);

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan;
    logic           grant_hit;
    logic           can_accept;
    logic           accept;
    logic [2:0]     a_g;
    logic           sel_g;
    logic [1:0]     dp_out;

    // First valid requester at or after rr_ptr, modulo NREQ.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!grant_hit && req_valid[scan]) begin
                grant_hit = 1'b1;
                grant_idx = scan;
            end
        end
    end

    always_comb begin
        a_g   = '0;
        sel_g = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_g   = req_a[3*i +: 3];
                sel_g = req_sel[i];
            end
        end
    end

    add3_sel_dp #(.ADDC(ADDC)) u_dp (
        .a   (a_g),
        .sel (sel_g),
        .out (dp_out)
    );

    assign accept    = grant_hit & can_accept;
    assign req_ready = (NREQ'(1) << grant_idx) & {NREQ{accept}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FULL;
            FULL:    if (rsp_ready && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Draining and refilling in the same cycle keeps one result per cycle.
    always_comb begin
        rsp_valid  = (state == FULL);
        can_accept = (state == IDLE) | rsp_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_out <= '0;
            rsp_id  <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            rsp_out <= dp_out;
            rsp_id  <= grant_idx;
            rr_ptr  <= IDW'(rr_next(int'(grant_idx), NREQ));
        end
    end

`ifdef ADDER_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (rsp_valid && !rsp_ready && (|req_valid) && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adder4_rr_sequencer.sv
// Scoreboard bench for adder4_rr_sequencer; honours ADDER_SEQ_STATS_EN when defined.
module tb_adder4_rr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [11:0] req_a = '0;
    logic [3:0]  req_sel = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_out;
    logic [1:0]  rsp_id;
`ifdef ADDER_SEQ_STATS_EN
    logic [7:0]  stall_cnt;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] out;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    // Per-requester results for a = {7,0,6,5}, sel = {0,1,1,0} (req3..req0).
    logic [1:0] exp_out [4] = '{2'b10, 2'b01, 2'b11, 2'b10};

    int         t1_a   [7] = '{5, 5, 7, 7, 0, 0, 6};
    logic       t1_sel [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] t1_exp [7] = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};

    adder4_rr_sequencer #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_id    (rsp_id)
`ifdef ADDER_SEQ_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp_id", 32'(rsp_id), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_out", 32'(rsp_out), 32'(e.out));
            end
        end
    end

    task automatic set_ops();
        req_a   = {3'd7, 3'd0, 3'd6, 3'd5};
        req_sel = 4'b0110;
    endtask

    task automatic issue_one(input int i, input int a, input logic sel, input logic [1:0] exp);
        @(posedge clk); #1;
        req_a[3*i +: 3] = 3'(a);
        req_sel[i]      = sel;
        req_valid       = 4'(1) << i;
        @(negedge clk);
        chk("single_grant", 32'(req_ready), 32'(4'(1) << i));
        chk("single_vld_at_grant", 32'(rsp_valid), 32'd0);
        sb.push_back('{id: 2'(i), out: exp});
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("single_vld_next", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef ADDER_SEQ_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Datapath truth table through requester 0
        for (int v = 0; v < 7; v++) issue_one(0, t1_a[v], t1_sel[v], t1_exp[v]);

        // Move rr_ptr to 3, then wrap 3 -> 0
        issue_one(2, 6, 1'b1, 2'b01);
        set_ops();
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("wrap_first", 32'(req_ready), 32'b1000);
        sb.push_back('{id: 2'd3, out: exp_out[3]});
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_second", 32'(req_ready), 32'b0001);
        sb.push_back('{id: 2'd0, out: exp_out[0]});
        @(posedge clk); #1;
        req_valid = '0;

        // Park rr_ptr at 0, then all four requesters continuously valid
        issue_one(3, 7, 1'b0, 2'b10);
        set_ops();
        @(posedge clk); #1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(4'(1) << (k % 4)));
            if (k > 0) chk("rr_vld", 32'(rsp_valid), 32'd1);
            sb.push_back('{id: 2'(k % 4), out: exp_out[k % 4]});
            @(posedge clk); #1;
        end
        req_valid = '0;

        // Backpressure: req0 result held for 5 cycles with req1, req2 waiting
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("bp_setup_grant", 32'(req_ready), 32'b0001);
        sb.push_back('{id: 2'd0, out: exp_out[0]});
        @(posedge clk); #1;
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready_zero", 32'(req_ready), 32'd0);
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            chk("bp_out_stable", 32'(rsp_out), 32'(exp_out[0]));
            chk("bp_id_stable", 32'(rsp_id), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(req_ready), 32'b0010);
`ifdef ADDER_SEQ_STATS_EN
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
        sb.push_back('{id: 2'd1, out: exp_out[1]});
        @(posedge clk); #1;
        req_valid = '0;

        // Asynchronous reset with a response pending
        @(posedge clk); #1;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("ar_grant", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("ar_vld_before", 32'(rsp_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld", 32'(rsp_valid), 32'd0);
        chk("ar_out", 32'(rsp_out), 32'd0);
        chk("ar_id", 32'(rsp_id), 32'd0);
`ifdef ADDER_SEQ_STATS_EN
        chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("ar_req0_first", 32'(req_ready), 32'b0001);
        sb.push_back('{id: 2'd0, out: exp_out[0]});
        @(posedge clk); #1;
        req_valid = '0;

`ifdef ADDER_SEQ_STATS_EN
        // Long stall saturates the counter
        @(posedge clk); #1;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("sat_grant", 32'(req_ready), 32'b0001);
        sb.push_back('{id: 2'd0, out: exp_out[0]});
        repeat (302) @(posedge clk);
        @(negedge clk);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFF);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
